// File: rtl/firo_trng_ctrl.sv
// rtl/firo_trng_ctrl.sv - Fibonacci ring-oscillator TRNG sequencer
// Warm-up, divided sampling into words, valid/ready delivery, repetition-count health test.
module firo_trng_ctrl #(
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int WORD_W        = 64,
  parameter int REP_LIMIT     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_fail,
  input  logic              ro_bit,
  output logic              ro_en,
  output logic              dff_en,
  output logic [WORD_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int DCW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD_W + 1);
  localparam int RCW = $clog2(REP_LIMIT + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [RCW-1:0] REP_MAX   = RCW'(REP_LIMIT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WARMUP  = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  logic [2:0]     state;
  logic [WCW-1:0] warm_cnt;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [RCW-1:0] run_cnt;
  logic           last_bit;

  logic           tick;
  logic [RCW-1:0] run_next;
  logic           rep_hit;
  logic           word_done;

  assign tick      = (state == S_COLLECT) && (div_cnt == DIV_LAST);
  assign word_done = (bit_cnt == BIT_LAST);
  // run_cnt == 0 marks the first sample of a session, which always starts a new run
  assign run_next  = ((run_cnt == '0) || (ro_bit != last_bit)) ? RCW'(1) : run_cnt + RCW'(1);
  assign rep_hit   = (run_next == REP_MAX);

  assign busy = (state == S_WARMUP) || (state == S_COLLECT) || (state == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      run_cnt     <= '0;
      last_bit    <= 1'b0;
      ro_en       <= 1'b0;
      dff_en      <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ro_en  <= 1'b0;
          dff_en <= 1'b0;
          if (start && !stop) begin
            state    <= S_WARMUP;
            warm_cnt <= '0;
            run_cnt  <= '0;
            ro_en    <= 1'b1;
            dff_en   <= 1'b1;
          end
        end

        S_WARMUP: begin
          if (stop) begin
            state      <= S_IDLE;
            ro_en      <= 1'b0;
            dff_en     <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
          end else if (warm_cnt == WARM_LAST) begin
            state   <= S_COLLECT;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + WCW'(1);
          end
        end

        S_COLLECT: begin
          if (stop) begin
            state      <= S_IDLE;
            ro_en      <= 1'b0;
            dff_en     <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
          end else if (tick) begin
            div_cnt  <= '0;
            run_cnt  <= run_next;
            last_bit <= ro_bit;
            // A failing sample wins over word completion; the partial word is dropped
            if (rep_hit) begin
              state       <= S_FAIL;
              health_fail <= 1'b1;
              ro_en       <= 1'b0;
              dff_en      <= 1'b0;
              data        <= '0;
            end else begin
              data    <= {data[WORD_W-2:0], ro_bit};
              bit_cnt <= bit_cnt + BCW'(1);
              if (word_done) begin
                state      <= S_HOLD;
                data_valid <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end

        S_HOLD: begin
          if (stop) begin
            state      <= S_IDLE;
            ro_en      <= 1'b0;
            dff_en     <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
          end else if (data_ready) begin
            state      <= S_COLLECT;
            data_valid <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
          end
        end

        S_FAIL: begin
          ro_en      <= 1'b0;
          dff_en     <= 1'b0;
          data_valid <= 1'b0;
          if (clear_fail) begin
            state       <= S_IDLE;
            health_fail <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          ro_en       <= 1'b0;
          dff_en      <= 1'b0;
          data_valid  <= 1'b0;
          health_fail <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_firo_trng_ctrl.sv
// tb/tb_firo_trng_ctrl.sv - scoreboard bench for firo_trng_ctrl
// Directed words with hand-computed values; a monitor pops expected words on each handshake.
module tb_firo_trng_ctrl;

  localparam int WARM = 4;
  localparam int DIV  = 2;
  localparam int WW   = 8;
  localparam int REP  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          clear_fail = 1'b0;
  logic          ro_bit = 1'b0;
  logic          data_ready = 1'b0;
  logic          ro_en;
  logic          dff_en;
  logic [WW-1:0] data;
  logic          data_valid;
  logic          busy;
  logic          health_fail;

  int vectors = 0;
  int miscompares = 0;
  logic [WW-1:0] sb[$];

  firo_trng_ctrl #(
    .WARMUP_CYCLES(WARM),
    .SAMPLE_DIV   (DIV),
    .WORD_W       (WW),
    .REP_LIMIT    (REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .clear_fail (clear_fail),
    .ro_bit     (ro_bit),
    .ro_en      (ro_en),
    .dff_en     (dff_en),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake sampled mid low phase, well after the bench drives inputs on negedge
  always @(negedge clk) begin
    #2;
    if (rst_n && data_valid && data_ready && !stop) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(data), 32'hFFFF_FFFF);
      end else begin
        chk("word", 32'(data), 32'(sb.pop_front()));
      end
    end
  end

  // Ends just after the edge that enters COLLECT, at a negedge
  task automatic start_gen();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ro_en_after_start", 32'(ro_en), 32'd1);
    repeat (WARM) @(posedge clk);
    @(negedge clk);
  endtask

  // One bit per DIV-cycle window; ends at the negedge after the last tick
  task automatic feed(input logic [WW-1:0] w, input string tag);
    for (int i = WW - 1; i >= 0; i--) begin
      ro_bit = w[i];
      @(posedge clk);
      @(negedge clk);
      if (i == 0) chk({tag, "_valid_early"}, 32'(data_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_dff_en", 32'(dff_en), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fail", 32'(health_fail), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word 1: alternating samples starting with 1
    sb.push_back(8'hAA);
    start_gen();
    feed(8'hAA, "w1");
    chk("w1_valid", 32'(data_valid), 32'd1);
    chk("w1_busy", 32'(busy), 32'd1);

    // Backpressure
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_data", 32'(data), 32'hAA);
      chk("bp_valid", 32'(data_valid), 32'd1);
    end
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    chk("hs1_valid_drop", 32'(data_valid), 32'd0);
    chk("hs1_ro_en", 32'(ro_en), 32'd1);

    // Word 2 back-to-back, 16 COLLECT cycles after handshake
    sb.push_back(8'h3C);
    feed(8'h3C, "w2");
    chk("w2_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    chk("hs2_valid_drop", 32'(data_valid), 32'd0);

    // Word 3 with start held high during COLLECT; then stop wins over handshake
    start = 1'b1;
    feed(8'h5A, "w3");
    start = 1'b0;
    chk("w3_valid", 32'(data_valid), 32'd1);
    chk("w3_data", 32'(data), 32'h5A);
    stop = 1'b1;
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    data_ready = 1'b0;
    chk("stop_valid", 32'(data_valid), 32'd0);
    chk("stop_ro_en", 32'(ro_en), 32'd0);
    chk("stop_dff_en", 32'(dff_en), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stop_no_word", 32'(data_valid), 32'd0);
    chk("stop_stays_idle", 32'(ro_en), 32'd0);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("startstop_ro_en", 32'(ro_en), 32'd0);
    chk("startstop_busy", 32'(busy), 32'd0);
    start = 1'b0;
    stop  = 1'b0;

    // Health failure: stuck-at-1, fifth tick lands 10 edges after COLLECT entry
    start_gen();
    ro_bit = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_fail_hf", 32'(health_fail), 32'd0);
    chk("pre_fail_ro_en", 32'(ro_en), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("fail_hf", 32'(health_fail), 32'd1);
    chk("fail_ro_en", 32'(ro_en), 32'd0);
    chk("fail_dff_en", 32'(dff_en), 32'd0);
    chk("fail_valid", 32'(data_valid), 32'd0);
    chk("fail_busy", 32'(busy), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("fail_ignores_start", 32'(health_fail), 32'd1);
    chk("fail_ignores_start_ro", 32'(ro_en), 32'd0);
    clear_fail = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_fail = 1'b0;
    chk("clear_hf", 32'(health_fail), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("clear_idle_ro_en", 32'(ro_en), 32'd0);

    // Asynchronous reset mid-COLLECT
    ro_bit = 1'b0;
    start_gen();
    ro_bit = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ro_en", 32'(ro_en), 32'd0);
    chk("arst_dff_en", 32'(dff_en), 32'd0);
    chk("arst_data", 32'(data), 32'd0);
    chk("arst_valid", 32'(data_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fail", 32'(health_fail), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_ro_en", 32'(ro_en), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
